// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   ARB_N       number of requesters
//   ARB_IDW     width of a requester index
//   arb_state_e arbiter state encoding (IDLE=0, GRANT=1)
package arb_pkg;

    localparam int ARB_N   = 4;
    localparam int ARB_IDW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Finds the first set bit of req searching upward from ptr with wrap
// (ptr, ptr+1, ... mod ARB_N).
//   req     [ARB_N-1:0]   request vector
//   ptr     [ARB_IDW-1:0] index with highest priority this round
//   pick    [ARB_N-1:0]   one-hot winner, zero when no request
//   pick_id [ARB_IDW-1:0] binary index of the winner, zero when no request
//   any                   at least one request is present
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]   req,
    input  logic [ARB_IDW-1:0] ptr,
    output logic [ARB_N-1:0]   pick,
    output logic [ARB_IDW-1:0] pick_id,
    output logic               any
);

    logic [ARB_IDW-1:0] w_idx;
    logic               w_found;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < ARB_N; k++) begin
            // Index arithmetic is ARB_IDW bits wide, so it wraps naturally.
            w_idx = ptr + ARB_IDW'(k);
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                pick_id     = w_idx;
                w_found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter driving the one-hot sel of a 4:1 mux.
// A grant is held while its owner keeps requesting; every release is
// followed by exactly one all-zero cycle before the next grant.
//
// Optional feature: define RR_ARB4_TIMEOUT_EN to force release of a grant
// held for MAX_HOLD cycles while another requester waits (preempt pulses).
// Without it, grants are held indefinitely and preempt is constant 0.
//
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles (2..256), timeout build only
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   req        request vector
//   gnt        registered one-hot grant or zero (mux sel)
//   gnt_valid  registered OR of gnt
//   gnt_id     registered index of the granted bit, 0 when idle
//   preempt    registered one-cycle pulse on forced release
//
// State | meaning
// IDLE  | no grant; pick next owner from the rotating pointer
// GRANT | one owner holds the mux until it drops req (or times out)
module rr_arb4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ARB_N-1:0]   req,
    output logic [ARB_N-1:0]   gnt,
    output logic               gnt_valid,
    output logic [ARB_IDW-1:0] gnt_id,
    output logic               preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 2..256");
    end

    arb_state_e         r_state, w_state_nxt;
    logic [ARB_N-1:0]   r_gnt, w_gnt_nxt;
    logic               r_gnt_valid, w_gnt_valid_nxt;
    logic [ARB_IDW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [ARB_IDW-1:0] r_ptr, w_ptr_nxt;
    logic               r_preempt, w_preempt_nxt;

    logic [ARB_N-1:0]   w_pick;
    logic [ARB_IDW-1:0] w_pick_id;
    logic               w_any;

`ifdef RR_ARB4_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              w_others;

    // Someone other than the current owner is waiting.
    assign w_others = |(req & ~r_gnt);
`endif

    rr_pick u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .pick    (w_pick),
        .pick_id (w_pick_id),
        .any     (w_any)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_id_nxt    = r_gnt_id;
        w_ptr_nxt       = r_ptr;
        w_preempt_nxt   = 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
        w_hold_cnt_nxt  = r_hold_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_gnt_id_nxt    = '0;
`ifdef RR_ARB4_TIMEOUT_EN
                w_hold_cnt_nxt  = '0;
`endif
                if (w_any) begin
                    w_state_nxt     = GRANT;
                    w_gnt_nxt       = w_pick;
                    w_gnt_valid_nxt = 1'b1;
                    w_gnt_id_nxt    = w_pick_id;
                    w_ptr_nxt       = w_pick_id + 2'd1;
                end
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_gnt_id_nxt    = '0;
                end
`ifdef RR_ARB4_TIMEOUT_EN
                else if (r_hold_cnt == HOLD_LAST && w_others) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_gnt_id_nxt    = '0;
                    w_preempt_nxt   = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    // Saturates at HOLD_LAST when nobody else is waiting.
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_gnt_id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            r_preempt   <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_preempt   <= w_preempt_nxt;
`ifdef RR_ARB4_TIMEOUT_EN
            r_hold_cnt  <= w_hold_cnt_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: behavioural reference model compared
// every cycle, plus directed sequences with literal expectations.
module tb_rr_arb4;

`ifdef RR_ARB4_TIMEOUT_EN
    localparam int MAX_HOLD = 4;
`else
    localparam int MAX_HOLD = 16;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the mux, whose turn is next, how long held.
    int m_owner = -1;
    int m_next  = 0;
    int m_held  = 0;
    bit m_pre   = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner = -1;
            m_next  = 0;
            m_held  = 0;
            m_pre   = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        int cand;
                        cand = (m_next + k) % 4;
                        if (m_owner < 0 && req[cand]) m_owner = cand;
                    end
                    m_next = (m_owner + 1) % 4;
                    m_held = 1;
                end
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end
`ifdef RR_ARB4_TIMEOUT_EN
            else if (m_held >= MAX_HOLD && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
`endif
        end
    end

    // Per-cycle comparison, including the mux the grant drives.
    always @(negedge clk) begin
        logic [3:0] e_gnt;
        logic [1:0] mux_out;
        e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("model_gnt", gnt, e_gnt);
        chk("model_valid", gnt_valid, (m_owner >= 0));
        chk("model_id", gnt_id, (m_owner < 0) ? 0 : m_owner);
        chk("model_preempt", preempt, m_pre);
        chk("onehot", ($countones(gnt) <= 1), 1);
        mux_out = ({2{gnt[0]}} & 2'd0) | ({2{gnt[1]}} & 2'd1) |
                  ({2{gnt[2]}} & 2'd2) | ({2{gnt[3]}} & 2'd3);
        if (gnt_valid) chk("mux_out", mux_out, gnt_id);
    end

    task automatic do_reset();
        req = 4'b0000;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    logic [3:0] exp_seq [5];

    initial begin
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Idle after reset
        do_reset();
        repeat (5) @(posedge clk);
        #1 chk("idle_gnt", gnt, 4'b0000);
        chk("idle_valid", gnt_valid, 0);
        chk("idle_preempt", preempt, 0);

        // Hold and release with exactly one gap cycle
        do_reset();
        req = 4'b1010;
        @(posedge clk); #1 chk("hold_gnt", gnt, 4'b0010);
        chk("hold_id", gnt_id, 1);
        @(posedge clk); @(posedge clk); #1 chk("hold_gnt3", gnt, 4'b0010);
        #1 req = 4'b1000;
        @(posedge clk); #1 chk("gap_gnt", gnt, 4'b0000);
        @(posedge clk); #1 chk("next_gnt", gnt, 4'b1000);
        chk("next_id", gnt_id, 3);

        // Rotation with wrap from 3 to 0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 chk("rot_gnt", gnt, exp_seq[i]);
            @(posedge clk); #1 req = 4'b1111 & ~exp_seq[i];
            @(posedge clk); #1 chk("rot_gap", gnt, 4'b0000);
            #1 req = 4'b1111;
        end

        // Asynchronous reset mid-grant
        do_reset();
        req = 4'b0100;
        @(posedge clk); #1 chk("pre_rst_gnt", gnt, 4'b0100);
        #2 rstn = 1'b0;
        #1 chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_valid", gnt_valid, 0);
        chk("async_rst_id", gnt_id, 0);
        req = 4'b0101;
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1 chk("post_rst_gnt", gnt, 4'b0001);

`ifdef RR_ARB4_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles while another waits
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 chk("to_hold", gnt, 4'b0001);
        end
        @(posedge clk); #1 chk("to_gap", gnt, 4'b0000);
        chk("to_preempt", preempt, 1);
        @(posedge clk); #1 chk("to_next", gnt, 4'b0010);
        chk("to_preempt_clr", preempt, 0);
        #1 req = 4'b0001;
        @(posedge clk); @(posedge clk); #1 chk("solo_gnt", gnt, 4'b0001);
        repeat (6) begin
            @(posedge clk); #1 chk("solo_hold", gnt, 4'b0001);
            chk("solo_preempt", preempt, 0);
        end
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 31) == 0) begin
                req = 4'($urandom_range(0, 15));
            end else begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            if (c == 1500) begin
                rstn = 1'b0;
                #3 rstn = 1'b1;
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
